// File: rtl/spi_master_rw.sv
// spi_master_rw: full-duplex SPI master with configurable mode, bit order and per-slave chip selects
module spi_master_rw #(
  parameter int   DATA_WIDTH = 16,
  parameter int   NUM_CS     = 2,
  parameter int   CLK_DIV    = 1,
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter logic CSNPOL     = 1'b0,
  parameter logic MSB_FIRST  = 1'b1,
  localparam int  CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [DATA_WIDTH-1:0] wdat,
  input  logic [CSW-1:0]        cs_sel,
  input  logic                  load,
  input  logic                  miso,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rdat,
  output logic                  rvalid,
  output logic                  sck,
  output logic                  mosi,
  output logic [NUM_CS-1:0]     csn
);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, LEAD = 3'd2, TRAIL = 3'd3, HOLD = 3'd4;
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  logic [2:0] r_state;
  logic [HW-1:0] r_hcnt;
  logic [BW-1:0] r_bit;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rdat;
  logic [NUM_CS-1:0] r_csn, w_onehot;
  logic r_busy, r_rvalid, r_sck, r_mosi;
  logic w_start, w_hdone, w_last, w_to_lead, w_tx_first, w_wdat_first;
  logic [DATA_WIDTH-1:0] w_tx_shift, w_wdat_shift, w_rx_next;
  assign w_start      = (r_state == IDLE) && load && (32'(cs_sel) < NUM_CS);
  assign w_hdone      = r_hcnt == '0;
  assign w_last       = r_bit == B_LAST;
  assign w_to_lead    = w_hdone && (r_state == SETUP || (r_state == TRAIL && !w_last));
  assign w_onehot     = NUM_CS'(1) << cs_sel;
  assign w_tx_first   = MSB_FIRST ? r_tx[DATA_WIDTH-1] : r_tx[0];
  assign w_wdat_first = MSB_FIRST ? wdat[DATA_WIDTH-1] : wdat[0];
  assign w_tx_shift   = MSB_FIRST ? {r_tx[DATA_WIDTH-2:0], 1'b0} : {1'b0, r_tx[DATA_WIDTH-1:1]};
  assign w_wdat_shift = MSB_FIRST ? {wdat[DATA_WIDTH-2:0], 1'b0} : {1'b0, wdat[DATA_WIDTH-1:1]};
  assign w_rx_next    = MSB_FIRST ? {r_rx[DATA_WIDTH-2:0], miso} : {miso, r_rx[DATA_WIDTH-1:1]};
  // Transfer sequencer: SETUP, DATA_WIDTH x (LEAD, TRAIL), HOLD, each phase H cycles
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state  <= IDLE;
      r_hcnt   <= '0;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rdat   <= '0;
      r_csn    <= {NUM_CS{~CSNPOL}};
      r_busy   <= 1'b0;
      r_rvalid <= 1'b0;
      r_sck    <= CPOL;
      r_mosi   <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_start) begin
        r_state <= SETUP;
        r_hcnt  <= H_LAST;
        r_busy  <= 1'b1;
        r_csn   <= CSNPOL ? w_onehot : ~w_onehot;
        r_tx    <= CPHA ? wdat : w_wdat_shift;
        if (!CPHA) r_mosi <= w_wdat_first;
      end else if (w_to_lead) begin
        r_state <= LEAD;
        r_hcnt  <= H_LAST;
        r_sck   <= ~CPOL;
        r_bit   <= (r_state == TRAIL) ? r_bit + BW'(1) : '0;
        if (CPHA) begin
          r_mosi <= w_tx_first;
          r_tx   <= w_tx_shift;
        end else r_rx <= w_rx_next;
      end else if (r_state == LEAD && w_hdone) begin
        r_state <= TRAIL;
        r_hcnt  <= H_LAST;
        r_sck   <= CPOL;
        if (CPHA) r_rx <= w_rx_next;
        else if (!w_last) begin
          r_mosi <= w_tx_first;
          r_tx   <= w_tx_shift;
        end
      end else if (r_state == TRAIL && w_hdone) begin
        r_state <= HOLD;
        r_hcnt  <= H_LAST;
      end else if (r_state == HOLD && w_hdone) begin
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_csn    <= {NUM_CS{~CSNPOL}};
        r_rdat   <= r_rx;
        r_rvalid <= 1'b1;
      end else if (r_state != IDLE) r_hcnt <= r_hcnt - HW'(1);
    end
  end
  assign busy   = r_busy;
  assign rdat   = r_rdat;
  assign rvalid = r_rvalid;
  assign sck    = r_sck;
  assign mosi   = r_mosi;
  assign csn    = r_csn;
endmodule

// File: tb/tb_spi_master_rw.sv
// tb_spi_master_rw: randomized self-checking bench over three SPI master configurations
module tb_spi_master_rw;
  localparam int   DW_A   [3] = '{8, 16, 8};
  localparam int   H_A    [3] = '{2, 1, 3};
  localparam int   NCS_A  [3] = '{2, 3, 1};
  localparam logic CPOL_A [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic CPHA_A [3] = '{1'b0, 1'b1, 1'b1};
  localparam logic MSB_A  [3] = '{1'b1, 1'b1, 1'b0};
  localparam logic CSNP_A [3] = '{1'b0, 1'b0, 1'b1};
  logic clk = 1'b0, arstn = 1'b1;
  int n_chk = 0, n_fail = 0;
  logic ld [3], lb [3], miso_a [3], busy_a [3], rv_a [3], sck_a [3], mosi_a [3];
  logic [31:0] wd_a [3], slv [3], rd_a [3];
  int cs_a [3];
  logic [7:0] csn_a [3];
  logic [7:0] wd0, wd2, rd0, rd2;
  logic [15:0] wd1, rd1;
  logic [0:0] cs0, cs2, csn2;
  logic [1:0] cs1, csn0;
  logic [2:0] csn1;
  int busy_n [3], rise_n [3], lead [3], samp_n [3], csn_bad [3], rv_n [3];
  logic [31:0] got_mosi [3], rd_got [3];
  logic busy_q [3] = '{1'b0, 1'b0, 1'b0};
  logic sck_q [3] = '{1'b0, 1'b1, 1'b0};
  always #5 clk = ~clk;
  assign wd0 = wd_a[0][7:0];
  assign wd1 = wd_a[1][15:0];
  assign wd2 = wd_a[2][7:0];
  assign cs0 = cs_a[0][0:0];
  assign cs1 = cs_a[1][1:0];
  assign cs2 = cs_a[2][0:0];
  assign rd_a[0] = 32'(rd0);
  assign rd_a[1] = 32'(rd1);
  assign rd_a[2] = 32'(rd2);
  assign csn_a[0] = 8'(csn0);
  assign csn_a[1] = 8'(csn1);
  assign csn_a[2] = 8'(csn2);
  spi_master_rw #(.DATA_WIDTH(8), .NUM_CS(2), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .CSNPOL(1'b0), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .arstn(arstn), .wdat(wd0), .cs_sel(cs0), .load(ld[0]), .miso(miso_a[0]), .busy(busy_a[0]),
    .rdat(rd0), .rvalid(rv_a[0]), .sck(sck_a[0]), .mosi(mosi_a[0]), .csn(csn0));
  spi_master_rw #(.DATA_WIDTH(16), .NUM_CS(3), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1), .CSNPOL(1'b0), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .arstn(arstn), .wdat(wd1), .cs_sel(cs1), .load(ld[1]), .miso(miso_a[1]), .busy(busy_a[1]),
    .rdat(rd1), .rvalid(rv_a[1]), .sck(sck_a[1]), .mosi(mosi_a[1]), .csn(csn1));
  spi_master_rw #(.DATA_WIDTH(8), .NUM_CS(1), .CLK_DIV(3), .CPOL(1'b0), .CPHA(1'b1), .CSNPOL(1'b1), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .arstn(arstn), .wdat(wd2), .cs_sel(cs2), .load(ld[2]), .miso(miso_a[2]), .busy(busy_a[2]),
    .rdat(rd2), .rvalid(rv_a[2]), .sck(sck_a[2]), .mosi(mosi_a[2]), .csn(csn2));
  function automatic string tg(input int i, input string s);
    return $sformatf("u%0d_%s", i, s);
  endfunction
  function automatic logic [7:0] csn_want(input int i, input int cs, input logic act);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < NCS_A[i]; j++) v[j] = (act && j == cs) ? CSNP_A[i] : ~CSNP_A[i];
    return v;
  endfunction
  // Slave: word bit k is presented after k leading edges (CPHA=0) or after the (k+1)th (CPHA=1)
  function automatic logic sbit(input int i, input logic [31:0] s, input int n);
    int k;
    k = CPHA_A[i] ? n - 1 : n;
    if (k < 0 || k >= DW_A[i]) return 1'b0;
    return MSB_A[i] ? s[DW_A[i]-1-k] : s[k];
  endfunction
  always_comb for (int i = 0; i < 3; i++) miso_a[i] = lb[i] ? mosi_a[i] : sbit(i, slv[i], lead[i]);
  // Bus monitor, sampled on the falling clk edge away from DUT updates
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_a[i] && !busy_q[i]) begin
        busy_n[i] = 0; rise_n[i] = 0; lead[i] = 0; samp_n[i] = 0; got_mosi[i] = '0; csn_bad[i] = 0; rv_n[i] = 0;
      end
      if (busy_a[i]) begin
        busy_n[i]++;
        if (csn_a[i] !== csn_want(i, cs_a[i], 1'b1)) csn_bad[i]++;
      end
      if (sck_a[i] != sck_q[i]) begin
        if (sck_a[i]) rise_n[i]++;
        if (sck_a[i] != CPOL_A[i]) lead[i]++;
        if ((sck_a[i] != CPOL_A[i]) != CPHA_A[i]) begin
          got_mosi[i] = MSB_A[i] ? {got_mosi[i][30:0], mosi_a[i]} : got_mosi[i] | (32'(mosi_a[i]) << samp_n[i]);
          samp_n[i]++;
        end
      end
      if (rv_a[i]) begin
        rv_n[i]++;
        rd_got[i] = rd_a[i];
      end
      busy_q[i] = busy_a[i];
      sck_q[i] = sck_a[i];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_rv(input int i, input int lim);
    int t;
    t = 0;
    while (!rv_a[i] && t < lim) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tg(i, "rvalid_seen"), 32'(rv_a[i]), 1);
  endtask
  task automatic xfer(input int i, input logic [31:0] w, input logic [31:0] s, input logic l, input int cs);
    logic [31:0] m, ew, wm;
    m = (32'd1 << DW_A[i]) - 32'd1;
    wm = w & m;
    ew = l ? wm : (s & m);
    wd_a[i] = wm; slv[i] = s & m; lb[i] = l; cs_a[i] = cs; ld[i] = 1'b1;
    @(posedge clk); #1 ld[i] = 1'b0;
    chk(tg(i, "busy_start"), 32'(busy_a[i]), 1);
    wait_rv(i, 2000);
    chk(tg(i, "busy_end"), 32'(busy_a[i]), 0);
    chk(tg(i, "csn_idle"), 32'(csn_a[i]), 32'(csn_want(i, 0, 1'b0)));
    chk(tg(i, "sck_idle"), 32'(sck_a[i]), 32'(CPOL_A[i]));
    repeat (3) @(posedge clk);
    #1;
    chk(tg(i, "rdat"), rd_got[i], ew);
    chk(tg(i, "rdat_hold"), rd_a[i], ew);
    chk(tg(i, "mosi_word"), got_mosi[i], wm);
    chk(tg(i, "mosi_hold"), 32'(mosi_a[i]), 32'(MSB_A[i] ? wm[0] : wm[DW_A[i]-1]));
    chk(tg(i, "busy_cycles"), busy_n[i], 2 * H_A[i] * (DW_A[i] + 1));
    chk(tg(i, "sck_rises"), rise_n[i], DW_A[i]);
    chk(tg(i, "csn_active_bad"), csn_bad[i], 0);
    chk(tg(i, "rvalid_cycles"), rv_n[i], 1);
  endtask
  task automatic ign(input int i, input int cs);
    cs_a[i] = cs; wd_a[i] = 32'h0000_FFFF; ld[i] = 1'b1;
    @(posedge clk); #1 ld[i] = 1'b0;
    chk(tg(i, "ign_busy"), 32'(busy_a[i]), 0);
    chk(tg(i, "ign_csn"), 32'(csn_a[i]), 32'(csn_want(i, 0, 1'b0)));
    repeat (3) @(posedge clk);
    #1;
    chk(tg(i, "ign_busy_late"), 32'(busy_a[i]), 0);
    chk(tg(i, "ign_rvalid"), 32'(rv_a[i]), 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      ld[i] = 1'b0; lb[i] = 1'b0; wd_a[i] = '0; slv[i] = '0; cs_a[i] = 0;
    end
    #1 arstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk(tg(i, "rst_busy"), 32'(busy_a[i]), 0);
      chk(tg(i, "rst_rvalid"), 32'(rv_a[i]), 0);
      chk(tg(i, "rst_rdat"), rd_a[i], 0);
      chk(tg(i, "rst_sck"), 32'(sck_a[i]), 32'(CPOL_A[i]));
      chk(tg(i, "rst_mosi"), 32'(mosi_a[i]), 0);
      chk(tg(i, "rst_csn"), 32'(csn_a[i]), 32'(csn_want(i, 0, 1'b0)));
    end
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    wd_a[0] = 32'hFF; cs_a[0] = 0; lb[0] = 1'b1; ld[0] = 1'b1;
    @(posedge clk); #1 ld[0] = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    chk("u0_busy_before_rst", 32'(busy_a[0]), 1);
    arstn = 1'b0;
    #1;
    chk("u0_abort_busy", 32'(busy_a[0]), 0);
    chk("u0_abort_sck", 32'(sck_a[0]), 0);
    chk("u0_abort_csn", 32'(csn_a[0]), 32'h3);
    chk("u0_abort_mosi", 32'(mosi_a[0]), 0);
    chk("u0_abort_rvalid", 32'(rv_a[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("u0_abort_rv_count", rv_n[0], 0);
    chk("u0_abort_rdat", rd_a[0], 0);
    arstn = 1'b1;
    xfer(0, 32'h96, 32'h0, 1'b1, 1);
    xfer(0, 32'hA5, 32'h0, 1'b1, 1);
    xfer(1, 32'h8001, 32'h3C5A, 1'b0, 0);
    xfer(2, 32'h01, 32'h0, 1'b1, 0);
    wd_a[0] = 32'h5A; cs_a[0] = 1; lb[0] = 1'b1; ld[0] = 1'b1;
    @(posedge clk); #1 ld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 wd_a[0] = 32'hFF;
    ld[0] = 1'b1;
    @(posedge clk); #1 ld[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1 wd_a[0] = 32'h00;
    ld[0] = 1'b1;
    @(posedge clk); #1 ld[0] = 1'b0;
    wait_rv(0, 200);
    chk("u0_gap_busy", 32'(busy_a[0]), 0);
    chk("u0_gap_csn", 32'(csn_a[0]), 32'h3);
    wd_a[0] = 32'hC3; ld[0] = 1'b1;
    @(negedge clk); #1;
    chk("u0_b2b_rdat", rd_got[0], 32'h5A);
    chk("u0_b2b_mosi", got_mosi[0], 32'h5A);
    chk("u0_b2b_busy_cycles", busy_n[0], 36);
    @(posedge clk); #1 ld[0] = 1'b0;
    chk("u0_restart_busy", 32'(busy_a[0]), 1);
    chk("u0_restart_csn", 32'(csn_a[0]), 32'h1);
    wait_rv(0, 200);
    chk("u0_restart_rdat", rd_a[0], 32'hC3);
    repeat (3) @(posedge clk);
    #1;
    chk("u0_restart_mosi", got_mosi[0], 32'hC3);
    ign(1, 3);
    ign(2, 1);
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < 3; i++)
        xfer(i, $urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, NCS_A[i] - 1)));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
